// File: rtl/apb_lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_lcd_pkg
//  Description : Register offsets, PULSE field layout and parameter limits
//                shared by the APB LCD control block.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_lcd_pkg;

    // Parameter limits
    localparam int unsigned c_MAX_NOUT  = 16;
    localparam int unsigned c_MAX_NIN   = 8;
    localparam int unsigned c_MAX_CNT_W = 16;

    // Register byte offsets
    localparam logic [7:0] c_OFF_OUT   = 8'h00;
    localparam logic [7:0] c_OFF_SET   = 8'h04;
    localparam logic [7:0] c_OFF_CLR   = 8'h08;
    localparam logic [7:0] c_OFF_TGL   = 8'h0C;
    localparam logic [7:0] c_OFF_PULSE = 8'h10;
    localparam logic [7:0] c_OFF_IN    = 8'h14;
    localparam logic [7:0] c_OFF_IEN   = 8'h18;
    localparam logic [7:0] c_OFF_IPEND = 8'h1C;

    // PULSE register field positions
    localparam int unsigned c_PULSE_BUSY_BIT = 31;
    localparam int unsigned c_PULSE_IDX_LSB  = 16;
    localparam int unsigned c_PULSE_IDX_W    = 4;

endpackage
`default_nettype wire

// File: rtl/sync_fall.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fall
//  Description : Two-flop synchronizer for one asynchronous input plus a
//                falling-edge detector on the synchronized level. All flops
//                reset high so an idle-high input produces no edge after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fall (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and previous-level history, preset to idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/apb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : apb_lcd_ctrl
//  Description : APB3 slave driving LCD control pins (CD, reset, backlight)
//                with set/clear/toggle access, a one-shot pulse generator on
//                a selectable pin, and falling-edge interrupt capture on
//                synchronized input pins (touch PENIRQ and others).
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_lcd_ctrl
    import apb_lcd_pkg::*;
#(
    parameter int unsigned     NOUT     = 2,
    parameter int unsigned     NIN      = 1,
    parameter int unsigned     CNT_W    = 16,
    parameter logic [NOUT-1:0] OUT_INIT = '0
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  logic [31:0]     PADDR,
    input  logic [31:0]     PWDATA,
    output logic [31:0]     PRDATA,
    output logic            PREADY,
    output logic            PSLVERR,
    output logic [NOUT-1:0] PIN_OUT,
    input  logic [NIN-1:0]  PIN_IN,
    output logic            IRQ
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------
    if ((NOUT == 0) || (NOUT > c_MAX_NOUT)) begin : g_bad_nout
        $error("apb_lcd_ctrl: NOUT must be 1..16");
    end
    if ((NIN == 0) || (NIN > c_MAX_NIN)) begin : g_bad_nin
        $error("apb_lcd_ctrl: NIN must be 1..8");
    end
    if ((CNT_W == 0) || (CNT_W > c_MAX_CNT_W)) begin : g_bad_cnt_w
        $error("apb_lcd_ctrl: CNT_W must be 1..16");
    end

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NOUT-1:0]          r_out;
    logic                     r_busy;
    logic [CNT_W-1:0]         r_cnt;
    logic [c_PULSE_IDX_W-1:0] r_idx;
    logic [NIN-1:0]           r_ien;
    logic [NIN-1:0]           r_ipend;
    logic                     r_irq;

    // ------------------------------------------------------------------
    // Address decode and access qualification
    // ------------------------------------------------------------------
    logic [7:0]               w_off;
    logic                     w_access;
    logic                     w_mapped;
    logic [c_PULSE_IDX_W-1:0] w_wr_idx;
    logic [CNT_W-1:0]         w_wr_cnt;
    logic                     w_wr_cnt_nz;
    logic                     w_idx_bad;
    logic                     w_pulse_err;
    logic                     w_err;
    logic                     w_commit;
    logic                     w_pulse_start;
    logic                     w_we_ien;
    logic                     w_we_ipend;
    logic [NIN-1:0]           w_ipend_clr;
    logic [NOUT-1:0]          w_wdat_out;
    logic [NOUT-1:0]          w_out_nxt;
    logic [NOUT-1:0]          w_pulse_mask;
    logic [NIN-1:0]           w_in_sync;
    logic [NIN-1:0]           w_fall;
    logic                     w_unused;

    // Only PADDR[7:2] selects a register; byte lanes are ignored
    assign w_off       = {PADDR[7:2], 2'b00};
    assign w_access    = PSEL & PENABLE;
    assign w_mapped    = (w_off <= c_OFF_IPEND);

    assign w_wr_idx    = PWDATA[c_PULSE_IDX_LSB +: c_PULSE_IDX_W];
    assign w_wr_cnt    = PWDATA[CNT_W-1:0];
    assign w_wr_cnt_nz = (w_wr_cnt != '0);
    assign w_idx_bad   = (32'(w_wr_idx) >= NOUT);

    // A zero-count PULSE write is a silent no-op, so it never raises an error
    assign w_pulse_err = (w_off == c_OFF_PULSE) && w_wr_cnt_nz && (r_busy || w_idx_bad);

    assign w_err = !w_mapped
                 || (PWRITE && (w_off == c_OFF_IN))
                 || (PWRITE && w_pulse_err);

    // Erroring accesses change no state
    assign w_commit      = w_access & PWRITE & ~w_err;
    assign w_pulse_start = w_commit && (w_off == c_OFF_PULSE) && w_wr_cnt_nz;
    assign w_we_ien      = w_commit && (w_off == c_OFF_IEN);
    assign w_we_ipend    = w_commit && (w_off == c_OFF_IPEND);
    assign w_ipend_clr   = w_we_ipend ? PWDATA[NIN-1:0] : '0;
    assign w_wdat_out    = PWDATA[NOUT-1:0];

    assign PREADY  = 1'b1;
    assign PSLVERR = w_access & w_err;

    // Fold bits that no register uses into one sink
    assign w_unused = ^{PADDR[31:8], PADDR[1:0], PWDATA};

    // ------------------------------------------------------------------
    // Output base level: OUT / SET / CLR / TGL
    // ------------------------------------------------------------------
    // Next base level from the four output-register aliases
    always_comb begin
        w_out_nxt = r_out;
        if (w_commit) begin
            case (w_off)
                c_OFF_OUT: w_out_nxt = w_wdat_out;
                c_OFF_SET: w_out_nxt = r_out | w_wdat_out;
                c_OFF_CLR: w_out_nxt = r_out & ~w_wdat_out;
                c_OFF_TGL: w_out_nxt = r_out ^ w_wdat_out;
                default:   w_out_nxt = r_out;
            endcase
        end
    end

    // Output base-level register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_out <= OUT_INIT;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pulse generator: inverts one pin for r_cnt cycles
    // ------------------------------------------------------------------
    // Load on an accepted PULSE write, then count down to zero
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_idx  <= '0;
        end else if (w_pulse_start) begin
            r_busy <= 1'b1;
            r_cnt  <= w_wr_cnt;
            r_idx  <= w_wr_idx;
        end else if (r_busy) begin
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NOUT; g++) begin : g_pulse_mask
        assign w_pulse_mask[g] = r_busy && (r_idx == c_PULSE_IDX_W'(g));
    end

    // Pulse is an overlay, so base-level writes never cut it short
    assign PIN_OUT = r_out ^ w_pulse_mask;

    // ------------------------------------------------------------------
    // Input synchronizers and edge capture
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NIN; g++) begin : g_sync
        sync_fall u_sync_fall (
            .clk     (PCLK),
            .rst     (PRESET),
            .i_d     (PIN_IN[g]),
            .o_level (w_in_sync[g]),
            .o_fall  (w_fall[g])
        );
    end

    // Interrupt enable, pending flags (edge set beats W1C) and registered IRQ
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ien   <= '0;
            r_ipend <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_we_ien) begin
                r_ien <= PWDATA[NIN-1:0];
            end
            r_ipend <= (r_ipend & ~w_ipend_clr) | w_fall;
            r_irq   <= |(r_ipend & r_ien);
        end
    end

    assign IRQ = r_irq;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Combinational read data; zero when not selected or unmapped
    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (w_off)
                c_OFF_OUT, c_OFF_SET, c_OFF_CLR, c_OFF_TGL: begin
                    PRDATA[NOUT-1:0] = r_out;
                end
                c_OFF_PULSE: begin
                    PRDATA[c_PULSE_BUSY_BIT]                      = r_busy;
                    PRDATA[c_PULSE_IDX_LSB +: c_PULSE_IDX_W]      = r_idx;
                    PRDATA[CNT_W-1:0]                             = r_cnt;
                end
                c_OFF_IN:    PRDATA[NIN-1:0] = w_in_sync;
                c_OFF_IEN:   PRDATA[NIN-1:0] = r_ien;
                c_OFF_IPEND: PRDATA[NIN-1:0] = r_ipend;
                default:     PRDATA = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
